// File: rtl/picomips_pkg.sv
// Shared picoMIPS definitions: fetch-stage states, the decoder NOP opcode and default widths.
// Optional build macro used by the fetch stage: PCFETCH_SW_SYNC_EN.
package picomips_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } fetch_state_t;

  localparam logic [5:0] OPC_NOP   = 6'b111111;
  localparam int         PSIZE_DEF = 8;
  localparam int         ISIZE_DEF = 20;

endpackage

// File: rtl/pc_fetch_unit_sw_conditioner.sv
// Branch-status switch conditioner: 2-flop synchronizer followed by a stability filter.
// Compiled only when PCFETCH_SW_SYNC_EN is defined; output moves after STABLE_CYCLES steady samples.
`ifdef PCFETCH_SW_SYNC_EN
module sw_conditioner #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_i,
  output logic bstus_o
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bstus_q, bstus_d;

  always_comb begin
    cnt_d   = '0;
    bstus_d = bstus_q;
    // Count consecutive samples that disagree with the current output; any agreement restarts.
    if (sync2_q != bstus_q) begin
      if (cnt_q == CNT_LAST) begin
        bstus_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      bstus_q <= 1'b0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      bstus_q <= bstus_d;
    end
  end

  assign bstus_o = bstus_q;

endmodule
`endif

// File: rtl/pc_fetch_unit.sv
// picoMIPS program counter and fetch stage: IMEM_LAT-cycle FETCH, then EXEC until the decoder moves the PC.
// Define PCFETCH_SW_SYNC_EN to synchronize and debounce sw before it becomes Bstus.
module pc_fetch_unit
  import picomips_pkg::*;
#(
  parameter int PSIZE    = PSIZE_DEF,
  parameter int ISIZE    = ISIZE_DEF,
  parameter int IMEM_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCincr,
  input  logic             PCabsbranch,
  input  logic             PCrelbranch,
  input  logic [PSIZE-1:0] branch_off,
  input  logic             sw,
  output logic [PSIZE-1:0] imem_addr,
  input  logic [ISIZE-1:0] imem_rdata,
  output logic [ISIZE-1:0] instr,
  output logic [5:0]       opcode,
  output logic             instr_valid,
  output logic [PSIZE-1:0] pc,
  output logic             Bstus
);

  localparam logic [1:0] LAT_LAST = 2'(IMEM_LAT - 1);

  fetch_state_t     state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [PSIZE-1:0] pc_q, pc_d;
  logic [ISIZE-1:0] instr_q, instr_d;
  logic             valid_q, valid_d;
  logic             leave_exec;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    leave_exec = 1'b0;
    case (state_q)
      FETCH: begin
        if (cnt_q == LAT_LAST) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          cnt_d   = 2'd0;
          state_d = EXEC;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      EXEC: begin
        if (PCabsbranch) begin
          pc_d       = branch_off;
          leave_exec = 1'b1;
        end else if (PCrelbranch) begin
          // Same-width two's-complement add equals the sign-extended add modulo 2^PSIZE.
          pc_d       = pc_q + branch_off;
          leave_exec = 1'b1;
        end else if (PCincr) begin
          pc_d       = pc_q + PSIZE'(1);
          leave_exec = 1'b1;
        end
        if (leave_exec) begin
          valid_d = 1'b0;
          cnt_d   = 2'd0;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
        cnt_d   = 2'd0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= 2'd0;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  // Decoder sees NOP outside EXEC so it can never act twice on one instruction.
  assign opcode      = (state_q == EXEC) ? instr_q[ISIZE-1 -: 6] : OPC_NOP;

`ifdef PCFETCH_SW_SYNC_EN
  sw_conditioner #(
    .STABLE_CYCLES(4)
  ) u_sw_cond (
    .clk    (clk),
    .reset  (reset),
    .sw_i   (sw),
    .bstus_o(Bstus)
  );
`else
  assign Bstus = sw;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: two instances (IMEM_LAT=1 and 3) against a cycle-level model plus literal checks.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCincr, PCabsbranch, PCrelbranch, sw;
  logic [7:0]  branch_off;
  logic [7:0]  addr0, addr1, pc0, pc1;
  logic [19:0] rdata0, rdata1, instr0, instr1;
  logic [5:0]  opc0, opc1;
  logic        valid0, valid1, bst0, bst1;

  logic [19:0] mem [256];
  int          errors = 0;
  int          checks = 0;

  // Model state: per instance, PC, instruction, executing flag, FETCH cycles still to go.
  int          lat [2] = '{1, 3};
  logic [7:0]  m_pc [2];
  logic [19:0] m_instr [2];
  logic        m_valid [2];
  int          m_wait [2];

  always #5 clk = ~clk;

  assign rdata0 = mem[addr0];
  assign rdata1 = mem[addr1];

  pc_fetch_unit #(.PSIZE(8), .ISIZE(20), .IMEM_LAT(1)) dut0 (
    .clk(clk), .reset(reset), .PCincr(PCincr), .PCabsbranch(PCabsbranch),
    .PCrelbranch(PCrelbranch), .branch_off(branch_off), .sw(sw),
    .imem_addr(addr0), .imem_rdata(rdata0), .instr(instr0), .opcode(opc0),
    .instr_valid(valid0), .pc(pc0), .Bstus(bst0));

  pc_fetch_unit #(.PSIZE(8), .ISIZE(20), .IMEM_LAT(3)) dut1 (
    .clk(clk), .reset(reset), .PCincr(PCincr), .PCabsbranch(PCabsbranch),
    .PCrelbranch(PCrelbranch), .branch_off(branch_off), .sw(sw),
    .imem_addr(addr1), .imem_rdata(rdata1), .instr(instr1), .opcode(opc1),
    .instr_valid(valid1), .pc(pc1), .Bstus(bst1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_pc[d] = 8'h00; m_instr[d] = 20'h0; m_valid[d] = 1'b0; m_wait[d] = lat[d];
      end else if (!m_valid[d]) begin
        if (m_wait[d] == 1) begin
          m_instr[d] = mem[m_pc[d]];
          m_valid[d] = 1'b1;
        end else begin
          m_wait[d] = m_wait[d] - 1;
        end
      end else if (PCabsbranch || PCrelbranch || PCincr) begin
        int t;
        if (PCabsbranch)      t = int'(branch_off);
        else if (PCrelbranch) t = int'(m_pc[d]) + int'($signed(branch_off));
        else                  t = int'(m_pc[d]) + 1;
        m_pc[d]    = 8'((t % 256 + 256) % 256);
        m_valid[d] = 1'b0;
        m_wait[d]  = lat[d];
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (!reset) begin
      chk("model pc0", {24'h0, pc0}, {24'h0, m_pc[0]});
      chk("model addr0", {24'h0, addr0}, {24'h0, m_pc[0]});
      chk("model valid0", {31'h0, valid0}, {31'h0, m_valid[0]});
      chk("model instr0", {12'h0, instr0}, {12'h0, m_instr[0]});
      chk("model opcode0", {26'h0, opc0}, {26'h0, m_valid[0] ? m_instr[0][19:14] : 6'h3F});
      chk("model pc1", {24'h0, pc1}, {24'h0, m_pc[1]});
      chk("model addr1", {24'h0, addr1}, {24'h0, m_pc[1]});
      chk("model valid1", {31'h0, valid1}, {31'h0, m_valid[1]});
      chk("model instr1", {12'h0, instr1}, {12'h0, m_instr[1]});
      chk("model opcode1", {26'h0, opc1}, {26'h0, m_valid[1] ? m_instr[1][19:14] : 6'h3F});
`ifndef PCFETCH_SW_SYNC_EN
      chk("model bstus0", {31'h0, bst0}, {31'h0, sw});
      chk("model bstus1", {31'h0, bst1}, {31'h0, sw});
`endif
    end
  end

  task automatic wait_exec0();
    int n = 0;
    while (!valid0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!valid0) chk("timeout dut0 exec", 32'h0, 32'h1);
  endtask

  task automatic wait_exec1();
    int n = 0;
    while (!valid1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!valid1) chk("timeout dut1 exec", 32'h0, 32'h1);
  endtask

  // One EXEC edge with the given controls on dut0, then the resulting PC is checked.
  task automatic exec_ctl(input string name, input logic a, input logic r, input logic i,
                          input logic [7:0] off, input logic [7:0] exp_pc);
    wait_exec0();
    PCabsbranch = a; PCrelbranch = r; PCincr = i; branch_off = off;
    @(negedge clk);
    PCabsbranch = 1'b0; PCrelbranch = 1'b0; PCincr = 1'b0;
    chk(name, {24'h0, pc0}, {24'h0, exp_pc});
    chk({name, " valid"}, {31'h0, valid0}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {i[7:0] ^ 8'hA5, 12'(i * 37)};
    mem[0] = 20'h0ABCD;
    reset = 1'b1; PCincr = 1'b0; PCabsbranch = 1'b0; PCrelbranch = 1'b0;
    branch_off = 8'h00; sw = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset pc", {24'h0, pc0}, 32'h0);
    chk("reset addr", {24'h0, addr0}, 32'h0);
    chk("reset valid", {31'h0, valid0}, 32'h0);
    chk("reset instr", {12'h0, instr0}, 32'h0);
    chk("reset opcode", {26'h0, opc0}, 32'h3F);
    chk("reset bstus", {31'h0, bst0}, 32'h0);
    reset = 1'b0;

    @(negedge clk);
    chk("lat1 capture valid", {31'h0, valid0}, 32'h1);
    chk("lat1 capture instr", {12'h0, instr0}, 32'h0ABCD);
    chk("lat1 opcode", {26'h0, opc0}, 32'h02);
    chk("lat3 after 1 edge", {31'h0, valid1}, 32'h0);
    @(negedge clk);
    chk("lat3 after 2 edges", {31'h0, valid1}, 32'h0);
    @(negedge clk);
    chk("lat3 after 3 edges", {31'h0, valid1}, 32'h1);
    chk("lat3 capture instr", {12'h0, instr1}, 32'h0ABCD);

    // Continuous PCincr: pc advances every second cycle.
    PCincr = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("incr seq pc", {24'h0, pc0}, 32'((k + 1) / 2));
    end
    PCincr = 1'b0;

    exec_ctl("abs 40", 1'b1, 1'b0, 1'b0, 8'h40, 8'h40);
    exec_ctl("abs ff", 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF);
    exec_ctl("incr wrap", 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    exec_ctl("abs 10", 1'b1, 1'b0, 1'b0, 8'h10, 8'h10);
    exec_ctl("rel -4", 1'b0, 1'b1, 1'b0, 8'hFC, 8'h0C);
    exec_ctl("rel wrap", 1'b0, 1'b1, 1'b0, 8'hF8, 8'h04);
    exec_ctl("rel over incr", 1'b0, 1'b1, 1'b1, 8'h03, 8'h07);
    exec_ctl("all three", 1'b1, 1'b1, 1'b1, 8'h77, 8'h77);

    // BAT hold: instruction re-presented while no control is asserted.
    wait_exec0();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold pc", {24'h0, pc0}, 32'h77);
      chk("hold instr", {12'h0, instr0}, {12'h0, mem[8'h77]});
      chk("hold valid", {31'h0, valid0}, 32'h1);
      chk("hold opcode", {26'h0, opc0}, {26'h0, mem[8'h77][19:14]});
    end
    exec_ctl("hold release", 1'b0, 1'b0, 1'b1, 8'h00, 8'h78);
    chk("fetch opcode nop", {26'h0, opc0}, 32'h3F);

    // IMEM_LAT=3: capture on third FETCH cycle, then reset during the second.
    wait_exec1();
    PCincr = 1'b1;
    @(negedge clk);
    PCincr = 1'b0;
    chk("lat3 fetch c1", {31'h0, valid1}, 32'h0);
    @(negedge clk);
    chk("lat3 fetch c2", {31'h0, valid1}, 32'h0);
    @(negedge clk);
    chk("lat3 fetch c3", {31'h0, valid1}, 32'h0);
    @(negedge clk);
    chk("lat3 captured", {31'h0, valid1}, 32'h1);
    PCincr = 1'b1;
    @(negedge clk);
    PCincr = 1'b0;
    chk("lat3 refetch c1", {31'h0, valid1}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midfetch reset pc1", {24'h0, pc1}, 32'h0);
    chk("midfetch reset addr1", {24'h0, addr1}, 32'h0);
    chk("midfetch reset valid1", {31'h0, valid1}, 32'h0);
    chk("midfetch reset opcode1", {26'h0, opc1}, 32'h3F);
    chk("midfetch reset pc0", {24'h0, pc0}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("restart c1", {31'h0, valid1}, 32'h0);
    @(negedge clk);
    chk("restart c2", {31'h0, valid1}, 32'h0);
    @(negedge clk);
    chk("restart captured", {31'h0, valid1}, 32'h1);
    chk("restart instr", {12'h0, instr1}, 32'h0ABCD);

`ifdef PCFETCH_SW_SYNC_EN
    sw = 1'b1;
    repeat (3) @(negedge clk);
    sw = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("sw pulse filtered", {31'h0, bst0}, 32'h0);
    end
    sw = 1'b1;
    begin
      int n = 0;
      while (!bst0 && n < 7) begin
        @(negedge clk);
        n++;
      end
    end
    chk("sw held passes", {31'h0, bst0}, 32'h1);
    repeat (4) @(negedge clk);
    chk("sw held stays", {31'h0, bst1}, 32'h1);
    sw = 1'b0;
`else
    sw = 1'b1;
    #1;
    chk("bstus follows sw 1", {31'h0, bst0}, 32'h1);
    chk("bstus1 follows sw 1", {31'h0, bst1}, 32'h1);
    @(negedge clk);
    sw = 1'b0;
    #1;
    chk("bstus follows sw 0", {31'h0, bst0}, 32'h0);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
